// File: rtl/oric_tape_pkg.sv
// Shared types and constants for the Oric TAP cassette player.
package oric_tape_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tap_state_t;

  typedef enum logic {
    PH_HIGH,
    PH_LOW
  } cell_phase_t;

  localparam int STOP_CELLS = 4;
  localparam int DATA_BITS  = 8;

  // Number of clk_sys cycles in one timing unit.
  function automatic int unit_cycles(input int clk_hz, input int unit_us);
    return clk_hz / 1000000 * unit_us;
  endfunction

endpackage

// File: rtl/tape_fifo.sv
// Single-clock byte FIFO with show-ahead output and a flush that keeps a same-cycle write.
module tape_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr,
  input  logic [7:0]    din,
  input  logic          rd,
  output logic [7:0]    dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 2**AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign push  = wr && (flush || !full);
  assign pop   = rd && !empty && !flush;
  assign dout  = mem[rd_ptr];

  // Storage array; a write during flush lands in slot 0 so it survives as the new head.
  always_ff @(posedge clk) begin
    if (push) mem[flush ? '0 : wr_ptr] <= din;
  end

  // Pointers and occupancy; flush empties the queue except for a simultaneous write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= AW'(push);
      level  <= (AW+1)'(push);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/tap_player.sv
// Streams downloaded TAP bytes out as Oric fast-format cassette cells.
module tap_player
  import oric_tape_pkg::*;
#(
  parameter int CLK_HZ  = 24000000,
  parameter int UNIT_US = 208,
  parameter int FIFO_AW = 4
) (
  input  logic               clk_sys,
  input  logic               I_RESET,
  input  logic               ioctl_download,
  input  logic               ioctl_wr,
  input  logic [7:0]         ioctl_dout,
  output logic               ioctl_wait,
  input  logic               play,
  output logic               tape_out,
  output logic               busy,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int UNIT_CYC = unit_cycles(CLK_HZ, UNIT_US);
  localparam int TIMER_W  = $clog2(UNIT_CYC + 1);
  localparam int DEPTH    = 2**FIFO_AW;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(UNIT_CYC - 1);
  localparam logic [FIFO_AW:0]   WAIT_LEVEL = (FIFO_AW+1)'(DEPTH - 2);
  localparam logic [2:0]         LAST_DATA  = 3'(DATA_BITS - 1);
  localparam logic [2:0]         LAST_STOP  = 3'(STOP_CELLS - 1);

  tap_state_t          state, state_next;
  cell_phase_t         phase;
  logic [TIMER_W-1:0]  timer;
  logic                low_cnt;
  logic [2:0]          bit_cnt;
  logic [7:0]          shift_reg;
  logic                parity_bit;
  logic                dl_q;
  logic                dl_rise;
  logic                fifo_rd;
  logic [7:0]          fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                in_cell;
  logic                unit_end;
  logic                cell_bit;
  logic                cell_done;

  assign dl_rise   = ioctl_download && !dl_q;
  assign in_cell   = state inside {START, DATA, PARITY, STOP};
  assign unit_end  = in_cell && play && (timer == TIMER_LAST);
  assign cell_done = unit_end && (phase == PH_LOW) && (cell_bit || low_cnt);
  assign tape_out  = in_cell && (phase == PH_HIGH);
  assign busy      = (state != IDLE) || !fifo_empty;

  tape_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk_sys),
    .rst_n (I_RESET),
    .flush (dl_rise),
    .wr    (ioctl_wr),
    .din   (ioctl_dout),
    .rd    (fifo_rd),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Bit value carried by the cell currently being emitted.
  always_comb begin
    cell_bit = 1'b1;
    case (state)
      START:   cell_bit = 1'b0;
      DATA:    cell_bit = shift_reg[0];
      PARITY:  cell_bit = parity_bit;
      default: cell_bit = 1'b1;
    endcase
  end

  // Download edge detector, sticky overflow flag and registered backpressure.
  always_ff @(posedge clk_sys or negedge I_RESET) begin
    if (!I_RESET) begin
      dl_q       <= 1'b0;
      overflow   <= 1'b0;
      ioctl_wait <= 1'b0;
    end else begin
      dl_q       <= ioctl_download;
      ioctl_wait <= (fifo_level >= WAIT_LEVEL);
      if (dl_rise)
        overflow <= 1'b0;
      else if (ioctl_wr && fifo_full)
        overflow <= 1'b1;
    end
  end

  // Serialiser state register.
  always_ff @(posedge clk_sys or negedge I_RESET) begin
    if (!I_RESET) state <= IDLE;
    else          state <= state_next;
  end

  // Frame sequencing; a new download aborts everything back to IDLE.
  always_comb begin
    state_next = state;
    fifo_rd    = 1'b0;
    case (state)
      IDLE:    if (!fifo_empty) state_next = LOAD;
      LOAD: begin
        fifo_rd    = 1'b1;
        state_next = START;
      end
      START:   if (cell_done) state_next = DATA;
      DATA:    if (cell_done && bit_cnt == LAST_DATA) state_next = PARITY;
      PARITY:  if (cell_done) state_next = STOP;
      STOP:    if (cell_done && bit_cnt == LAST_STOP) state_next = fifo_empty ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
    if (dl_rise) begin
      state_next = IDLE;
      fifo_rd    = 1'b0;
    end
  end

  // Cell timer, phase tracking, bit counters and the byte shift register.
  always_ff @(posedge clk_sys or negedge I_RESET) begin
    if (!I_RESET) begin
      timer      <= '0;
      phase      <= PH_HIGH;
      low_cnt    <= 1'b0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else if (dl_rise) begin
      timer      <= '0;
      phase      <= PH_HIGH;
      low_cnt    <= 1'b0;
      bit_cnt    <= '0;
    end else if (state == LOAD) begin
      shift_reg  <= fifo_dout;
      parity_bit <= ~^fifo_dout;
      timer      <= '0;
      phase      <= PH_HIGH;
      low_cnt    <= 1'b0;
      bit_cnt    <= '0;
    end else if (unit_end) begin
      timer <= '0;
      if (phase == PH_HIGH) begin
        phase   <= PH_LOW;
        low_cnt <= 1'b0;
      end else if (cell_done) begin
        phase   <= PH_HIGH;
        low_cnt <= 1'b0;
        if (state == DATA) begin
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= (bit_cnt == LAST_DATA) ? 3'd0 : bit_cnt + 1'b1;
        end else if (state == STOP) begin
          bit_cnt   <= bit_cnt + 1'b1;
        end
      end else begin
        low_cnt <= 1'b1;
      end
    end else if (in_cell && play) begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_tap_player.sv
// Directed bench for tap_player using a shortened 10-cycle timing unit.
module tb_tap_player;

  localparam int UNIT  = 10;
  localparam int AW    = 4;
  localparam int BOUND = 4 * UNIT;

  logic          clk_sys = 1'b0;
  logic          I_RESET = 1'b0;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [7:0]    ioctl_dout = 8'h00;
  logic          play = 1'b0;
  logic          ioctl_wait;
  logic          tape_out;
  logic          busy;
  logic          overflow;
  logic [AW:0]   fifo_level;

  int total = 0;
  int bad   = 0;
  int hi_len [14];
  int lo_len [14];
  int frame_len;

  tap_player #(
    .CLK_HZ  (2000000),
    .UNIT_US (5),
    .FIFO_AW (AW)
  ) dut (
    .clk_sys        (clk_sys),
    .I_RESET        (I_RESET),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .play           (play),
    .tape_out       (tape_out),
    .busy           (busy),
    .overflow       (overflow),
    .fifo_level     (fifo_level)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk_sys);
    ioctl_wr   = 1'b1;
    ioctl_dout = b;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic new_download();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic wait_high(input string name);
    int n = 0;
    while (tape_out !== 1'b1 && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    total++;
    if (tape_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s start: tape_out=%b want 1 within 20 cycles", name, tape_out);
    end
  endtask

  // Measures high/low run lengths of 14 cells, starting on the first high sample.
  task automatic measure_frame();
    frame_len = 0;
    for (int c = 0; c < 14; c++) begin
      hi_len[c] = 0;
      lo_len[c] = 0;
      while (tape_out === 1'b1 && hi_len[c] < BOUND) begin
        hi_len[c]++;
        @(negedge clk_sys);
      end
      while (tape_out === 1'b0 && busy === 1'b1 && lo_len[c] < BOUND) begin
        lo_len[c]++;
        @(negedge clk_sys);
      end
      frame_len += hi_len[c] + lo_len[c];
    end
  endtask

  task automatic test_reset();
    I_RESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      ioctl_download = 1'($urandom_range(0, 1));
      ioctl_wr       = 1'($urandom_range(0, 1));
      ioctl_dout     = 8'($urandom_range(0, 255));
      play           = 1'($urandom_range(0, 1));
    end
    @(negedge clk_sys);
    total += 5;
    if (tape_out !== 1'b0)    begin bad++; $display("[TB] FAIL reset tape_out: got %b want 0", tape_out); end
    if (ioctl_wait !== 1'b0)  begin bad++; $display("[TB] FAIL reset ioctl_wait: got %b want 0", ioctl_wait); end
    if (busy !== 1'b0)        begin bad++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    if (overflow !== 1'b0)    begin bad++; $display("[TB] FAIL reset overflow: got %b want 0", overflow); end
    if (fifo_level !== '0)    begin bad++; $display("[TB] FAIL reset fifo_level: got %0d want 0", fifo_level); end
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_dout     = 8'h00;
    play           = 1'b0;
    @(negedge clk_sys);
    I_RESET = 1'b1;
    repeat (20) @(negedge clk_sys);
    total += 2;
    if (tape_out !== 1'b0) begin bad++; $display("[TB] FAIL idle tape_out: got %b want 0", tape_out); end
    if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL idle busy: got %b want 0", busy); end
  endtask

  task automatic test_single_byte();
    int exp_lo [14] = '{2, 2,1,1,2,1,2,2,2, 2, 1,1,1,1};
    play = 1'b1;
    write_byte(8'h16);
    wait_high("single");
    measure_frame();
    for (int c = 0; c < 14; c++) begin
      total += 2;
      if (hi_len[c] !== UNIT) begin
        bad++; $display("[TB] FAIL single cell%0d high: got %0d want %0d", c, hi_len[c], UNIT);
      end
      if (lo_len[c] !== exp_lo[c] * UNIT) begin
        bad++; $display("[TB] FAIL single cell%0d low: got %0d want %0d", c, lo_len[c], exp_lo[c] * UNIT);
      end
    end
    total += 2;
    if (frame_len !== 35 * UNIT) begin
      bad++; $display("[TB] FAIL single frame length: got %0d want %0d", frame_len, 35 * UNIT);
    end
    if (busy !== 1'b0) begin
      bad++; $display("[TB] FAIL single busy after frame: got %b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    play = 1'b0;
    new_download();
    write_byte(8'hAA);
    repeat (5) @(negedge clk_sys);
    total++;
    if (fifo_level !== '0) begin
      bad++; $display("[TB] FAIL bp pre-level: got %0d want 0", fifo_level);
    end
    for (int k = 1; k <= 16; k++) begin
      ioctl_wr   = 1'b1;
      ioctl_dout = 8'(k);
      @(negedge clk_sys);
      total += 2;
      if (fifo_level !== (AW+1)'(k)) begin
        bad++; $display("[TB] FAIL bp level w%0d: got %0d want %0d", k, fifo_level, k);
      end
      if (ioctl_wait !== (k >= 15)) begin
        bad++; $display("[TB] FAIL bp ioctl_wait w%0d: got %b want %b", k, ioctl_wait, (k >= 15));
      end
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("[TB] FAIL bp overflow before drop: got %b want 0", overflow);
    end
    ioctl_dout = 8'hEE;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    total += 2;
    if (fifo_level !== 5'd16) begin
      bad++; $display("[TB] FAIL bp level after drop: got %0d want 16", fifo_level);
    end
    if (overflow !== 1'b1) begin
      bad++; $display("[TB] FAIL bp overflow after drop: got %b want 1", overflow);
    end
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b1;
    ioctl_dout     = 8'h5A;
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    total += 3;
    if (fifo_level !== 5'd1) begin
      bad++; $display("[TB] FAIL flush keep level: got %0d want 1", fifo_level);
    end
    if (overflow !== 1'b0) begin
      bad++; $display("[TB] FAIL flush overflow: got %b want 0", overflow);
    end
    if (tape_out !== 1'b0) begin
      bad++; $display("[TB] FAIL flush tape_out: got %b want 0", tape_out);
    end
  endtask

  task automatic test_pause();
    int active = 0;
    int glitch = 0;
    play = 1'b1;
    new_download();
    write_byte(8'h16);
    wait_high("pause");
    active = 1;
    repeat (2) begin
      @(negedge clk_sys);
      if (tape_out === 1'b1) active++;
    end
    play = 1'b0;
    repeat (25) begin
      @(negedge clk_sys);
      if (tape_out !== 1'b1) glitch++;
    end
    play = 1'b1;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk_sys);
      if (tape_out !== 1'b1) break;
      active++;
    end
    total += 2;
    if (glitch !== 0) begin
      bad++; $display("[TB] FAIL pause hold: got %0d changed samples want 0", glitch);
    end
    if (active !== UNIT) begin
      bad++; $display("[TB] FAIL pause high active: got %0d want %0d", active, UNIT);
    end
  endtask

  task automatic test_back_to_back();
    int exp_ff [14] = '{2, 1,1,1,1,1,1,1,1, 1, 1,1,1,1};
    int exp_00 [14] = '{2, 2,2,2,2,2,2,2,2, 1, 1,1,1,1};
    int extra;
    play = 1'b1;
    new_download();
    @(negedge clk_sys);
    ioctl_wr   = 1'b1;
    ioctl_dout = 8'hFF;
    @(negedge clk_sys);
    ioctl_dout = 8'h00;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
    wait_high("b2b");
    measure_frame();
    for (int c = 0; c < 14; c++) begin
      extra = (c == 13) ? 1 : 0;
      total += 2;
      if (hi_len[c] !== UNIT) begin
        bad++; $display("[TB] FAIL b2b ff cell%0d high: got %0d want %0d", c, hi_len[c], UNIT);
      end
      if (lo_len[c] !== exp_ff[c] * UNIT + extra) begin
        bad++; $display("[TB] FAIL b2b ff cell%0d low: got %0d want %0d", c, lo_len[c], exp_ff[c] * UNIT + extra);
      end
    end
    total++;
    if (frame_len !== 29 * UNIT + 1) begin
      bad++; $display("[TB] FAIL b2b ff frame length: got %0d want %0d", frame_len, 29 * UNIT + 1);
    end
    measure_frame();
    for (int c = 0; c < 14; c++) begin
      total += 2;
      if (hi_len[c] !== UNIT) begin
        bad++; $display("[TB] FAIL b2b 00 cell%0d high: got %0d want %0d", c, hi_len[c], UNIT);
      end
      if (lo_len[c] !== exp_00[c] * UNIT) begin
        bad++; $display("[TB] FAIL b2b 00 cell%0d low: got %0d want %0d", c, lo_len[c], exp_00[c] * UNIT);
      end
    end
    total += 2;
    if (frame_len !== 37 * UNIT) begin
      bad++; $display("[TB] FAIL b2b 00 frame length: got %0d want %0d", frame_len, 37 * UNIT);
    end
    if (busy !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b busy after frames: got %b want 0", busy);
    end
  endtask

  task automatic test_new_download();
    play = 1'b1;
    new_download();
    @(negedge clk_sys);
    ioctl_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ioctl_dout = 8'h11 + 8'(i);
      @(negedge clk_sys);
    end
    ioctl_wr = 1'b0;
    wait_high("abort");
    repeat (3 * UNIT + 3) @(negedge clk_sys);
    total += 2;
    if (tape_out !== 1'b1) begin
      bad++; $display("[TB] FAIL abort data high: got %b want 1", tape_out);
    end
    if (fifo_level !== 5'd5) begin
      bad++; $display("[TB] FAIL abort queued: got %0d want 5", fifo_level);
    end
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    total += 4;
    if (tape_out !== 1'b0)   begin bad++; $display("[TB] FAIL abort tape_out: got %b want 0", tape_out); end
    if (fifo_level !== '0)   begin bad++; $display("[TB] FAIL abort fifo_level: got %0d want 0", fifo_level); end
    if (overflow !== 1'b0)   begin bad++; $display("[TB] FAIL abort overflow: got %b want 0", overflow); end
    if (busy !== 1'b0)       begin bad++; $display("[TB] FAIL abort busy: got %b want 0", busy); end
    repeat (3) @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (10) @(negedge clk_sys);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("[TB] FAIL abort idle after: got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_backpressure();
    test_pause();
    test_back_to_back();
    test_new_download();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
